// File: rtl/handshake_mem_if.sv
// Request/response bundle between the datapath (MAR/MDR side) and handshake_mem.
// The master raises mov with a request and holds it until moc is seen.
interface handshake_mem_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  logic              mov;
  logic              rw;
  logic [1:0]        dtype;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              moc;
  logic              align_err;

  modport master (
    output mov, rw, dtype, sign, addr, data_in,
    input  data_out, moc, align_err
  );

  modport slave (
    input  mov, rw, dtype, sign, addr, data_in,
    output data_out, moc, align_err
  );
endinterface

// File: rtl/handshake_mem.sv
// Byte-addressed big-endian memory behind a MOV/MOC return-to-zero handshake
// with programmable latency, byte/half/word access and alignment checking.
module handshake_mem #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             clr,
  handshake_mem_if.slave  bus
);

  localparam int unsigned MEM_BYTES = 2 ** ADDR_W;
  localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [1:0]  DT_BYTE   = 2'b00;
  localparam logic [1:0]  DT_HALF   = 2'b01;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        dtype;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q;
  logic [31:0]       data_out_q, data_out_d;
  logic              moc_q, moc_d;
  logic              align_err_q, align_err_d;

  logic [7:0]        mem [MEM_BYTES];
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rdata_c;
  logic              misalign_c;
  logic              complete_c;
  logic              we_c;
  logic              unused_addr_hi_c;

  // Upper address bits are architecturally ignored.
  assign unused_addr_hi_c = ^bus.addr[31:ADDR_W];

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_out_q  <= '0;
      moc_q       <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      moc_q       <= moc_d;
      align_err_q <= align_err_d;
    end
  end

  // Request is frozen at the IDLE capture edge; later input changes are ignored.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      req_q <= '0;
    end else if (state_q == IDLE && bus.mov) begin
      req_q <= '{rw: bus.rw, dtype: bus.dtype, sign: bus.sign,
                 addr: bus.addr[ADDR_W-1:0], data: bus.data_in};
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.mov) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (!bus.mov)             state_d = IDLE;
        else if (cnt_q != '0)     cnt_d   = cnt_q - CNT_W'(1);
        else                      state_d = DONE;
      end
      DONE: begin
        if (!bus.mov) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Big-endian byte lanes with modulo-2**ADDR_W wrap.
  assign a0 = req_q.addr;
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rdata_c    = {b0, b1, b2, b3};
    misalign_c = 1'b0;
    case (req_q.dtype)
      DT_BYTE: rdata_c = {{24{req_q.sign & b0[7]}}, b0};
      DT_HALF: begin
        rdata_c    = {{16{req_q.sign & b0[7]}}, b0, b1};
        misalign_c = a0[0];
      end
      default: misalign_c = |a0[1:0];
    endcase
  end

  assign complete_c = (state_q == BUSY) && bus.mov && (cnt_q == '0);

  // Next values of the registered outputs and the array write strobe.
  always_comb begin
    data_out_d  = data_out_q;
    moc_d       = moc_q;
    align_err_d = align_err_q;
    we_c        = 1'b0;
    if (complete_c) begin
      moc_d       = 1'b1;
      align_err_d = misalign_c;
      if (misalign_c)    data_out_d = '0;
      else if (req_q.rw) data_out_d = rdata_c;
      we_c = !req_q.rw && !misalign_c && clr;
    end else if (state_q == DONE && !bus.mov) begin
      moc_d       = 1'b0;
      align_err_d = 1'b0;
    end
  end

  // Array contents survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (we_c) begin
      case (req_q.dtype)
        DT_BYTE: mem[a0] <= req_q.data[7:0];
        DT_HALF: begin
          mem[a0] <= req_q.data[15:8];
          mem[a1] <= req_q.data[7:0];
        end
        default: begin
          mem[a0] <= req_q.data[31:24];
          mem[a1] <= req_q.data[23:16];
          mem[a2] <= req_q.data[15:8];
          mem[a3] <= req_q.data[7:0];
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.moc       = moc_q;
  assign bus.align_err = align_err_q;

endmodule

// File: tb/tb_handshake_mem.sv
// Directed bench for handshake_mem: latency, endianness, extension,
// alignment, abort, wrap and reset behaviour, plus a LATENCY=1 instance.
module tb_handshake_mem;

  logic clk;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  handshake_mem_if bus ();
  handshake_mem_if bus1 ();

  handshake_mem #(.ADDR_W(9), .LATENCY(2)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  handshake_mem #(.ADDR_W(9), .LATENCY(1)) u_dut1 (
    .clk (clk),
    .clr (clr),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // One full handshake on the LATENCY=2 instance; inputs are scrambled after capture.
  task automatic do_op(input logic rw_i, input logic [1:0] dt, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output logic aerr, output int edges,
                       output logic held, output logic moc_after, output logic aerr_after,
                       output logic [31:0] rdata_after);
    @(negedge clk);
    bus.rw = rw_i; bus.dtype = dt; bus.sign = sg; bus.addr = a; bus.data_in = d;
    bus.mov = 1'b1;
    @(posedge clk); #1;
    bus.rw = ~rw_i; bus.dtype = ~dt; bus.sign = ~sg; bus.addr = ~a; bus.data_in = ~d;
    edges = 0;
    while (!bus.moc && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    rdata = bus.data_out;
    aerr  = bus.align_err;
    held  = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (!bus.moc || bus.data_out !== rdata || bus.align_err !== aerr) held = 1'b0;
    end
    @(negedge clk);
    bus.mov = 1'b0;
    @(posedge clk); #1;
    moc_after   = bus.moc;
    aerr_after  = bus.align_err;
    rdata_after = bus.data_out;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    bus.mov = 1'b0; bus.rw = 1'b0; bus.dtype = 2'b00; bus.sign = 1'b0;
    bus.addr = '0; bus.data_in = '0;
    bus1.mov = 1'b0; bus1.rw = 1'b0; bus1.dtype = 2'b00; bus1.sign = 1'b0;
    bus1.addr = '0; bus1.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.moc !== 1'b0) begin errors++; $display("FAIL reset_moc: got %b expected 0", bus.moc); end
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b expected 0", bus.align_err); end
    checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 00000000", bus.data_out); end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e;
    do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, rd, ae, e, h, ma, aea, rda);
    checks++; if (e !== 2) begin errors++; $display("FAIL write_latency: got %0d edges expected 2", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_keeps_data_out: got %h expected 00000000", rd); end
    do_op(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (e !== 2) begin errors++; $display("FAIL read_latency: got %0d edges expected 2", e); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_word4: got %h expected deadbeef", rd); end
    checks++; if (ae !== 1'b0) begin errors++; $display("FAIL read_word4_aerr: got %b expected 0", ae); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL done_hold: got %b expected 1", h); end
    checks++; if (ma !== 1'b0) begin errors++; $display("FAIL moc_drop: got %b expected 0", ma); end
    checks++; if (rda !== 32'hDEADBEEF) begin errors++; $display("FAIL data_out_after_drop: got %h expected deadbeef", rda); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e;
    do_op(1'b1, 2'b00, 1'b1, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte4_sext: got %h expected ffffffde", rd); end
    do_op(1'b1, 2'b00, 1'b0, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL byte4_zext: got %h expected 000000de", rd); end
    do_op(1'b1, 2'b01, 1'b1, 32'h6, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL half6_sext: got %h expected ffffbeef", rd); end
    do_op(1'b1, 2'b01, 1'b0, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL half4_zext: got %h expected 0000dead", rd); end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e;
    do_op(1'b0, 2'b00, 1'b0, 32'h5, 32'hAAAAAA12, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL byte_write_data_out: got %h expected 0000dead", rd); end
    do_op(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'hDE12BEEF) begin errors++; $display("FAIL byte_write_merge: got %h expected de12beef", rd); end
  endtask

  task automatic test_align();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e;
    do_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h01020304, rd, ae, e, h, ma, aea, rda);
    do_op(1'b1, 2'b10, 1'b0, 32'h6, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (ae !== 1'b1) begin errors++; $display("FAIL word6_aerr: got %b expected 1", ae); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word6_data: got %h expected 00000000", rd); end
    checks++; if (e !== 2) begin errors++; $display("FAIL word6_latency: got %0d edges expected 2", e); end
    checks++; if (aea !== 1'b0) begin errors++; $display("FAIL aerr_clear: got %b expected 0", aea); end
    do_op(1'b0, 2'b01, 1'b0, 32'h3, 32'h00005566, rd, ae, e, h, ma, aea, rda);
    checks++; if (ae !== 1'b1) begin errors++; $display("FAIL half3_aerr: got %b expected 1", ae); end
    do_op(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL half3_no_write_lo: got %h expected 01020304", rd); end
    do_op(1'b1, 2'b11, 1'b0, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'hDE12BEEF) begin errors++; $display("FAIL half3_no_write_hi: got %h expected de12beef", rd); end
    checks++; if (ae !== 1'b0) begin errors++; $display("FAIL dtype11_aerr: got %b expected 0", ae); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e; logic saw_moc;
    do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h11223344, rd, ae, e, h, ma, aea, rda);
    @(negedge clk);
    bus.rw = 1'b0; bus.dtype = 2'b10; bus.sign = 1'b0; bus.addr = 32'h8; bus.data_in = 32'h99999999;
    bus.mov = 1'b1;
    @(negedge clk);
    bus.mov = 1'b0;
    saw_moc = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.moc) saw_moc = 1'b1;
    end
    checks++; if (saw_moc !== 1'b0) begin errors++; $display("FAIL abort_moc: got %b expected 0", saw_moc); end
    do_op(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL abort_no_write: got %h expected 11223344", rd); end
    checks++; if (e !== 2) begin errors++; $display("FAIL after_abort_latency: got %0d edges expected 2", e); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e;
    do_op(1'b0, 2'b00, 1'b0, 32'h000001FF, 32'h0000007E, rd, ae, e, h, ma, aea, rda);
    do_op(1'b1, 2'b00, 1'b0, 32'h000003FF, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h0000007E) begin errors++; $display("FAIL wrap_3ff: got %h expected 0000007e", rd); end
    do_op(1'b1, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'h0000007E) begin errors++; $display("FAIL wrap_ffffffff: got %h expected 0000007e", rd); end
    do_op(1'b1, 2'b10, 1'b0, 32'h00000204, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'hDE12BEEF) begin errors++; $display("FAIL wrap_204: got %h expected de12beef", rd); end
  endtask

  task automatic test_reset_in_done();
    logic [31:0] rd, rda; logic ae, h, ma, aea; int e;
    @(negedge clk);
    bus.rw = 1'b1; bus.dtype = 2'b10; bus.sign = 1'b0; bus.addr = 32'h6; bus.data_in = '0;
    bus.mov = 1'b1;
    e = 0;
    @(posedge clk); #1;
    while (!bus.moc && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL pre_reset_aerr: got %b expected 1", bus.align_err); end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++; if (bus.moc !== 1'b0) begin errors++; $display("FAIL async_reset_moc: got %b expected 0", bus.moc); end
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL async_reset_aerr: got %b expected 0", bus.align_err); end
    bus.mov = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    do_op(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, rd, ae, e, h, ma, aea, rda);
    checks++; if (rd !== 32'hDE12BEEF) begin errors++; $display("FAIL mem_retained: got %h expected de12beef", rd); end
  endtask

  task automatic test_latency1();
    logic m0, m1;
    @(negedge clk);
    bus1.rw = 1'b0; bus1.dtype = 2'b10; bus1.addr = 32'h10; bus1.data_in = 32'h0BADCAFE;
    bus1.mov = 1'b1;
    @(posedge clk); #1; m0 = bus1.moc;
    @(posedge clk); #1; m1 = bus1.moc;
    checks++; if ({m0, m1} !== 2'b01) begin errors++; $display("FAIL lat1_write_timing: got %b expected 01", {m0, m1}); end
    @(negedge clk); bus1.mov = 1'b0;
    @(negedge clk);
    bus1.rw = 1'b1; bus1.addr = 32'h10; bus1.data_in = '0;
    bus1.mov = 1'b1;
    @(posedge clk); #1; m0 = bus1.moc;
    @(posedge clk); #1; m1 = bus1.moc;
    checks++; if ({m0, m1} !== 2'b01) begin errors++; $display("FAIL lat1_read_timing: got %b expected 01", {m0, m1}); end
    checks++; if (bus1.data_out !== 32'h0BADCAFE) begin errors++; $display("FAIL lat1_read_data: got %h expected 0badcafe", bus1.data_out); end
    @(negedge clk); bus1.mov = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus1.moc !== 1'b0) begin errors++; $display("FAIL lat1_moc_drop: got %b expected 0", bus1.moc); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sign_ext();
    test_byte_write();
    test_align();
    test_abort();
    test_wrap();
    test_reset_in_done();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
